// File: rtl/l1_ahb_mtx_pkg.sv
// l1_ahb_mtx_pkg: shared AHB encodings and address-phase bundle for the L1 AHB matrix
package l1_ahb_mtx_pkg;
    localparam int TRANS_W = 2;
    localparam int RESP_W  = 2;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 3;
    localparam int PROT_W  = 4;

    typedef enum logic [TRANS_W-1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [RESP_W-1:0] HRESP_OKAY  = 2'b00;
    localparam logic [RESP_W-1:0] HRESP_ERROR = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pend_st_e;

    typedef struct packed {
        logic               sel;
        logic [TRANS_W-1:0] trans;
        logic               write;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
        logic [PROT_W-1:0]  prot;
        logic               lock;
    } ap_ctrl_t;
endpackage

// File: rtl/l1_ahb_mtx_in_stage_if.sv
// l1_ahb_mtx_in_stage_if: master-side and decode-side signals of one matrix input stage
interface l1_ahb_mtx_in_stage_if #(parameter int ADDR_W = 32);
    logic              HSELS;
    logic [ADDR_W-1:0] HADDRS;
    logic [1:0]        HTRANSS;
    logic              HWRITES;
    logic [2:0]        HSIZES;
    logic [2:0]        HBURSTS;
    logic [3:0]        HPROTS;
    logic              HMASTLOCKS;
    logic              HREADYS;
    logic              HREADYOUTS;
    logic [1:0]        HRESPS;
    logic              HSELM;
    logic [ADDR_W-1:0] HADDRM;
    logic [1:0]        HTRANSM;
    logic              HWRITEM;
    logic [2:0]        HSIZEM;
    logic [2:0]        HBURSTM;
    logic [3:0]        HPROTM;
    logic              HMASTLOCKM;
    logic              req;
    logic              active_dec;
    logic              readyout_dec;
    logic [1:0]        resp_dec;

    modport slave (
        input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        input  active_dec, readyout_dec, resp_dec,
        output HREADYOUTS, HRESPS, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
        output HMASTLOCKM, req
    );

    modport master (
        output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
        output active_dec, readyout_dec, resp_dec,
        input  HREADYOUTS, HRESPS, HSELM, HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM,
        input  HMASTLOCKM, req
    );
endinterface

// File: rtl/l1_ahb_mtx_in_stage.sv
// l1_ahb_mtx_in_stage: per-master input stage, holds un-granted transfers; lock hold via L1AHBMTX_INSTG_LOCK_EN
module l1_ahb_mtx_in_stage
    import l1_ahb_mtx_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    l1_ahb_mtx_in_stage_if.slave bus
);
    pend_st_e          r_st, w_st_nxt;
    logic              r_dphase, w_dphase_nxt;
    logic [ADDR_W-1:0] r_addr;
    ap_ctrl_t          r_ctrl, w_live, w_out;
    logic              w_pend, w_accept, w_issue, w_load, w_lock_in, w_req_base;

    assign w_pend   = (r_st == ST_PEND);
    assign w_accept = bus.HSELS & bus.HTRANSS[1] & bus.HREADYS;
    assign w_issue  = bus.active_dec & (w_accept | (w_pend & bus.readyout_dec));
    assign w_load   = w_accept & ~bus.active_dec;

`ifdef L1AHBMTX_INSTG_LOCK_EN
    logic r_lock;
    assign w_lock_in = bus.HMASTLOCKS;
    // Remember the lock of the last completed address phase so req is kept between locked beats
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_lock <= 1'b0;
        else if (bus.HREADYS) r_lock <= bus.HSELS & bus.HMASTLOCKS;
    end
    assign bus.req = w_req_base | r_lock;
`else
    assign w_lock_in = 1'b0;
    assign bus.req   = w_req_base;
`endif

    assign w_live = '{sel: bus.HSELS, trans: bus.HTRANSS, write: bus.HWRITES, size: bus.HSIZES,
                      burst: bus.HBURSTS, prot: bus.HPROTS, lock: w_lock_in};

    // Pending-transfer state and data-phase flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_st     <= ST_IDLE;
            r_dphase <= 1'b0;
        end else begin
            r_st     <= w_st_nxt;
            r_dphase <= w_dphase_nxt;
        end
    end

    // Next state: hold on an un-granted accept, release once the slave takes the held transfer
    always_comb begin
        w_st_nxt     = r_st;
        w_dphase_nxt = r_dphase;
        if (r_st == ST_IDLE)
            w_st_nxt = w_load ? ST_PEND : ST_IDLE;
        else
            w_st_nxt = (bus.active_dec & bus.readyout_dec) ? ST_IDLE : ST_PEND;
        w_dphase_nxt = w_issue ? 1'b1 : (bus.readyout_dec ? 1'b0 : r_dphase);
    end

    // Address-phase capture bank, only written when a transfer must wait for its grant
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr <= '0;
            r_ctrl <= '0;
        end else if (w_load) begin
            r_addr <= bus.HADDRS;
            r_ctrl <= w_live;
        end
    end

    assign w_out          = w_pend ? r_ctrl : w_live;
    assign bus.HADDRM     = w_pend ? r_addr : bus.HADDRS;
    assign bus.HSELM      = w_out.sel;
    assign bus.HTRANSM    = w_out.trans;
    assign bus.HWRITEM    = w_out.write;
    assign bus.HSIZEM     = w_out.size;
    assign bus.HBURSTM    = w_out.burst;
    assign bus.HPROTM     = w_out.prot;
    assign bus.HMASTLOCKM = w_out.lock;
    assign w_req_base     = w_out.sel & w_out.trans[1];

    assign bus.HREADYOUTS = w_pend ? 1'b0 : (r_dphase ? bus.readyout_dec : 1'b1);
    assign bus.HRESPS     = r_dphase ? bus.resp_dec : HRESP_OKAY;
endmodule

// File: tb/tb_l1_ahb_mtx_in_stage.sv
// tb_l1_ahb_mtx_in_stage: directed checks of hold, wait states, responses, reset and lock
module tb_l1_ahb_mtx_in_stage;
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   total = 0;
    int   bad = 0;

    l1_ahb_mtx_in_stage_if #(.ADDR_W(32)) bus ();

    l1_ahb_mtx_in_stage #(.ADDR_W(32)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    assign bus.HREADYS = bus.HREADYOUTS;

    always @(posedge HCLK) begin
        if (HRESETn)
            assert (!(bus.HREADYS && !bus.HREADYOUTS))
            else begin
                bad++;
                $error("FAIL hready_overlap obs=%0b exp=0", bus.HREADYS);
            end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic act, input logic rdy,
                         input logic [1:0] rsp);
        bus.HSELS        = sel;
        bus.HTRANSS      = trans;
        bus.HWRITES      = wr;
        bus.HADDRS       = addr;
        bus.active_dec   = act;
        bus.readyout_dec = rdy;
        bus.resp_dec     = rsp;
    endtask

    initial begin
        bus.HSIZES     = 3'b010;
        bus.HBURSTS    = 3'b000;
        bus.HPROTS     = 4'b0011;
        bus.HMASTLOCKS = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00);
        #1;
        chk("rst_readyout", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("rst_resp", {30'b0, bus.HRESPS}, 32'd0);
        chk("rst_req", {31'b0, bus.req}, 32'd0);
        drive(1'b1, 2'b10, 1'b0, 32'h0000_1234, 1'b0, 1'b1, 2'b00);
        #1;
        chk("rst_live_addr", bus.HADDRM, 32'h0000_1234);
        chk("rst_live_req", {31'b0, bus.req}, 32'd1);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00);
        @(negedge HCLK);
        HRESETn = 1'b1;

        @(negedge HCLK);
        drive(1'b1, 2'b10, 1'b1, 32'h2000_0000, 1'b1, 1'b1, 2'b00);
        #1;
        chk("g_addr", bus.HADDRM, 32'h2000_0000);
        chk("g_write", {31'b0, bus.HWRITEM}, 32'd1);
        chk("g_req", {31'b0, bus.req}, 32'd1);
        chk("g_ready_ap", {31'b0, bus.HREADYOUTS}, 32'd1);
        @(negedge HCLK);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00);
        #1;
        chk("g_ready_dp", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("g_resp_dp", {30'b0, bus.HRESPS}, 32'd0);

        @(negedge HCLK);
        drive(1'b1, 2'b10, 1'b0, 32'h1000_0040, 1'b0, 1'b1, 2'b00);
        #1;
        chk("d_ready_ap", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("d_req_ap", {31'b0, bus.req}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            drive(1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, i == 2, 1'b1, 2'b00);
            #1;
            chk("d_wait", {31'b0, bus.HREADYOUTS}, 32'd0);
            chk("d_hold_addr", bus.HADDRM, 32'h1000_0040);
            chk("d_hold_trans", {30'b0, bus.HTRANSM}, 32'd2);
            chk("d_hold_write", {31'b0, bus.HWRITEM}, 32'd0);
            chk("d_hold_req", {31'b0, bus.req}, 32'd1);
        end
        @(negedge HCLK);
        drive(1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b00);
        #1;
        chk("d_ready_dp", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("d_resp_dp", {30'b0, bus.HRESPS}, 32'd0);
        chk("d_live_addr", bus.HADDRM, 32'hDEAD_BEEF);
        chk("d_req_off", {31'b0, bus.req}, 32'd0);

        @(negedge HCLK);
        drive(1'b1, 2'b10, 1'b0, 32'h3000_0000, 1'b1, 1'b1, 2'b00);
        #1;
        chk("e_req", {31'b0, bus.req}, 32'd1);
        @(negedge HCLK);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0, 2'b01);
        #1;
        chk("e1_ready", {31'b0, bus.HREADYOUTS}, 32'd0);
        chk("e1_resp", {30'b0, bus.HRESPS}, 32'd1);
        @(negedge HCLK);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
        #1;
        chk("e2_ready", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("e2_resp", {30'b0, bus.HRESPS}, 32'd1);
        @(negedge HCLK);
        #1;
        chk("e_after_resp", {30'b0, bus.HRESPS}, 32'd0);
        bus.resp_dec = 2'b00;

        for (int t = 0; t < 2; t++) begin
            @(negedge HCLK);
            drive(1'b1, 2'(t), 1'b0, 32'h0000_0100, 1'b0, 1'b1, 2'b00);
            #1;
            chk("ib_req", {31'b0, bus.req}, 32'd0);
            chk("ib_ready", {31'b0, bus.HREADYOUTS}, 32'd1);
            chk("ib_resp", {30'b0, bus.HRESPS}, 32'd0);
            @(negedge HCLK);
            #1;
            chk("ib_no_pend", {31'b0, bus.HREADYOUTS}, 32'd1);
        end

        @(negedge HCLK);
        drive(1'b1, 2'b10, 1'b1, 32'h4000_0000, 1'b0, 1'b1, 2'b00);
        @(negedge HCLK);
        drive(1'b0, 2'b00, 1'b0, 32'h5000_0000, 1'b0, 1'b1, 2'b00);
        #1;
        chk("r_pend_ready", {31'b0, bus.HREADYOUTS}, 32'd0);
        chk("r_pend_addr", bus.HADDRM, 32'h4000_0000);
        chk("r_pend_req", {31'b0, bus.req}, 32'd1);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("r_async_ready", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("r_async_req", {31'b0, bus.req}, 32'd0);
        chk("r_async_addr", bus.HADDRM, 32'h5000_0000);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        #1;
        chk("r_after_ready", {31'b0, bus.HREADYOUTS}, 32'd1);
        chk("r_after_addr", bus.HADDRM, 32'h5000_0000);

        bus.HBURSTS    = 3'b011;
        bus.HMASTLOCKS = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(negedge HCLK);
            drive(1'b1, b == 0 ? 2'b10 : (b == 2 ? 2'b01 : 2'b11), 1'b1,
                  32'h6000_0000 + 32'(b * 4), 1'b1, 1'b1, 2'b00);
            #1;
`ifdef L1AHBMTX_INSTG_LOCK_EN
            chk("l_req", {31'b0, bus.req}, 32'd1);
            chk("l_lockm", {31'b0, bus.HMASTLOCKM}, 32'd1);
`else
            chk("l_req", {31'b0, bus.req}, b == 2 ? 32'd0 : 32'd1);
            chk("l_lockm", {31'b0, bus.HMASTLOCKM}, 32'd0);
`endif
        end
        @(negedge HCLK);
        bus.HMASTLOCKS = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00);
        @(negedge HCLK);
        #1;
        chk("l_release_req", {31'b0, bus.req}, 32'd0);
        chk("l_release_lockm", {31'b0, bus.HMASTLOCKM}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
